// File: rtl/mdc_output_reorder.sv
// mdc_output_reorder: ping-pong reorder of two-lane bit-reversed FFT frames into a
// natural-order single-lane valid/ready stream.
module mdc_output_reorder #(
    parameter int DW     = 16,
    parameter int N_HALF = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic          in_start,
    output logic          in_ready,
    input  logic [DW-1:0] in_re0,
    input  logic [DW-1:0] in_im0,
    input  logic [DW-1:0] in_re1,
    input  logic [DW-1:0] in_im1,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_re,
    output logic [DW-1:0] out_im,
    output logic [4:0]    out_index,
    output logic          out_last,
    output logic          frame_err
);
    localparam logic [3:0] LAST_K = 4'(N_HALF - 1);

    typedef enum logic {WR_IDLE, WR_FILL} wr_state_t;

    wr_state_t       r_wst, w_wst_nxt;
    logic [3:0]      r_wr_cnt, w_wr_cnt_nxt, w_wr_addr;
    logic            r_wr_sel, r_rd_sel, r_f_sel;
    logic [1:0]      r_full, w_set, w_clr;
    logic [4:0]      r_f_cnt, r_s1_idx;
    logic            r_s1_vld;
    logic [2*DW-1:0] r_s1_data, w_rd_data;
    logic [2*DW-1:0] r_lo [0:1][0:15];
    logic [2*DW-1:0] r_hi [0:1][0:15];
    logic            w_acc, w_start_ok, w_fill_ok, w_we, w_err, w_done;
    logic            w_out_adv, w_s1_adv, w_fetch, w_xfer_last;

    assign in_ready  = !r_full[r_wr_sel];
    assign w_acc     = in_valid && in_ready;
    assign w_wr_addr = in_start ? 4'd0 : {r_wr_cnt[0], r_wr_cnt[1], r_wr_cnt[2], r_wr_cnt[3]};

    always_comb begin
        w_start_ok   = w_acc && in_start;
        w_fill_ok    = w_acc && !in_start && r_wst == WR_FILL;
        w_we         = w_start_ok || w_fill_ok;
        w_err        = w_acc && (in_start ? r_wst == WR_FILL : r_wst == WR_IDLE);
        w_done       = w_fill_ok && r_wr_cnt == LAST_K;
        w_wr_cnt_nxt = w_start_ok ? 4'd1 : w_fill_ok ? r_wr_cnt + 4'd1 : r_wr_cnt;
        w_wst_nxt    = w_start_ok ? WR_FILL : w_done ? WR_IDLE : r_wst;
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_lo[r_wr_sel][w_wr_addr] <= {in_re0, in_im0};
            r_hi[r_wr_sel][w_wr_addr] <= {in_re1, in_im1};
        end
    end

    // The fetch pointer runs at most two beats ahead of the output transfers, so it
    // can move on to the other buffer before the current frame's last beat leaves.
    assign w_out_adv   = !out_valid || out_ready;
    assign w_s1_adv    = !r_s1_vld || w_out_adv;
    assign w_fetch     = w_s1_adv && r_full[r_f_sel];
    assign w_xfer_last = out_valid && out_ready && out_last;
    assign w_rd_data   = r_f_cnt[4] ? r_hi[r_f_sel][r_f_cnt[3:0]] : r_lo[r_f_sel][r_f_cnt[3:0]];
    assign w_set       = w_done ? 2'b01 << r_wr_sel : 2'b00;
    assign w_clr       = w_xfer_last ? 2'b01 << r_rd_sel : 2'b00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wst     <= WR_IDLE;
            r_wr_cnt  <= '0;
            r_wr_sel  <= 1'b0;
            r_rd_sel  <= 1'b0;
            r_f_sel   <= 1'b0;
            r_f_cnt   <= '0;
            r_full    <= '0;
            r_s1_vld  <= 1'b0;
            r_s1_idx  <= '0;
            r_s1_data <= '0;
            out_valid <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
            out_index <= '0;
            out_last  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            r_wst     <= w_wst_nxt;
            r_wr_cnt  <= w_wr_cnt_nxt;
            r_wr_sel  <= r_wr_sel ^ w_done;
            r_rd_sel  <= r_rd_sel ^ w_xfer_last;
            r_full    <= (r_full | w_set) & ~w_clr;
            frame_err <= w_err;
            if (w_fetch) begin
                r_f_cnt <= r_f_cnt + 5'd1;
                r_f_sel <= r_f_sel ^ (r_f_cnt == 5'd31);
            end
            if (w_s1_adv) begin
                r_s1_vld <= w_fetch;
                if (w_fetch) begin
                    r_s1_data <= w_rd_data;
                    r_s1_idx  <= r_f_cnt;
                end
            end
            if (w_out_adv) begin
                out_valid <= r_s1_vld;
                if (r_s1_vld) begin
                    {out_re, out_im} <= r_s1_data;
                    out_index        <= r_s1_idx;
                    out_last         <= r_s1_idx == 5'd31;
                end
            end
        end
    end
endmodule

// File: tb/tb_mdc_output_reorder.sv
// tb_mdc_output_reorder: randomized frames checked against a queue-based model of the
// natural-order output stream, plus targeted timing, protocol-error and reset scenarios.
module tb_mdc_output_reorder;
    localparam int DW = 16;

    typedef struct {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        logic [4:0]    idx;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n, in_valid, in_start, in_ready, out_valid, out_ready, out_last, frame_err;
    logic [DW-1:0] in_re0, in_im0, in_re1, in_im1, out_re, out_im;
    logic [4:0]    out_index;

    int n_checks = 0, n_errors = 0;

    beat_t         exp_q[$];
    beat_t         held;
    logic          held_last, stall, building, exp_err;
    logic [DW-1:0] p_re[32], p_im[32], f_re[32], f_im[32];
    int            pk, model_full, err_count, seen_nr, cur_run, max_run;

    mdc_output_reorder #(.DW(DW), .N_HALF(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_start(in_start), .in_ready(in_ready),
        .in_re0(in_re0), .in_im0(in_im0), .in_re1(in_re1), .in_im1(in_im1),
        .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
        .out_index(out_index), .out_last(out_last), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    function automatic int bitrev5(input int x);
        int r = 0;
        for (int i = 0; i < 5; i++) if (x[i]) r |= 1 << (4 - i);
        return r;
    endfunction

    // Reference model: sampled mid-cycle, it predicts what the next rising edge does.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            model_full = 0;
            building = 1'b0;
            pk = 0;
            exp_err = 1'b0;
            stall = 1'b0;
            cur_run = 0;
        end else begin
            n_checks++;
            if (in_ready !== (model_full < 2)) begin
                n_errors++;
                $display("FAIL in_ready: got %b expected %b", in_ready, model_full < 2);
            end
            n_checks++;
            if (frame_err !== exp_err) begin
                n_errors++;
                $display("FAIL frame_err: got %b expected %b", frame_err, exp_err);
            end
            if (frame_err) err_count++;
            if (stall) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_re !== held.re || out_im !== held.im ||
                    out_index !== held.idx || out_last !== held_last) begin
                    n_errors++;
                    $display("FAIL stall_hold: got v=%b idx=%0d re=%h im=%h expected v=1 idx=%0d re=%h im=%h",
                             out_valid, out_index, out_re, out_im, held.idx, held.re, held.im);
                end
            end
            if (out_valid) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_out: got idx=%0d re=%h with no frame pending", out_index, out_re);
                end else if (out_re !== exp_q[0].re || out_im !== exp_q[0].im ||
                             out_index !== exp_q[0].idx || out_last !== (exp_q[0].idx == 5'd31)) begin
                    n_errors++;
                    $display("FAIL out_beat: got idx=%0d re=%h im=%h last=%b expected idx=%0d re=%h im=%h",
                             out_index, out_re, out_im, out_last, exp_q[0].idx, exp_q[0].re, exp_q[0].im);
                end
                if (out_ready && exp_q.size() != 0) begin
                    if (exp_q[0].idx == 5'd31) model_full--;
                    void'(exp_q.pop_front());
                end
            end
            stall = out_valid && !out_ready;
            held = '{re: out_re, im: out_im, idx: out_index};
            held_last = out_last;
            cur_run = (out_valid && out_ready) ? cur_run + 1 : 0;
            if (cur_run > max_run) max_run = cur_run;
            if (!in_ready) seen_nr++;
            exp_err = 1'b0;
            if (in_valid && in_ready) begin
                if (in_start) begin
                    exp_err = building;
                    building = 1'b1;
                    pk = 0;
                end
                if (!building) exp_err = 1'b1;
                else begin
                    p_re[bitrev5(2 * pk)] = in_re0;
                    p_im[bitrev5(2 * pk)] = in_im0;
                    p_re[bitrev5(2 * pk + 1)] = in_re1;
                    p_im[bitrev5(2 * pk + 1)] = in_im1;
                    pk++;
                    if (pk == 16) begin
                        for (int b = 0; b < 32; b++) exp_q.push_back('{re: p_re[b], im: p_im[b], idx: 5'(b)});
                        model_full++;
                        building = 1'b0;
                    end
                end
            end
        end
    end

    task automatic gen_frame(input bit ramp);
        for (int b = 0; b < 32; b++) begin
            f_re[b] = ramp ? 16'(b) : 16'($urandom);
            f_im[b] = ramp ? ~16'(b) : 16'($urandom);
        end
    endtask

    // Call just after a rising edge; returns just after the edge that accepted the pair.
    task automatic send_pair(input logic st, input int k);
        bit ok = 0;
        in_valid = 1'b1;
        in_start = st;
        in_re0 = f_re[bitrev5(2 * k)];
        in_im0 = f_im[bitrev5(2 * k)];
        in_re1 = f_re[bitrev5(2 * k + 1)];
        in_im1 = f_im[bitrev5(2 * k + 1)];
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            if (in_ready) ok = 1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        if (!ok) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_timeout: in_ready stayed %b, required 1", in_ready);
        end else begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_start = 1'b0;
    endtask

    task automatic send_frame(input int npairs);
        for (int k = 0; k < npairs; k++) send_pair(k == 0, k);
    endtask

    task automatic drain();
        bit done = 0;
        for (int t = 0; t < 1000 && !done; t++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0 && !out_valid) done = 1;
        end
        if (!done) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain_timeout: %0d beats still pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || out_re !== '0 || out_im !== '0 || out_index !== '0 ||
            out_last !== 1'b0 || frame_err !== 1'b0 || in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_state: got v=%b re=%h im=%h idx=%0d last=%b err=%b rdy=%b required 0/0/0/0/0/0/1",
                     out_valid, out_re, out_im, out_index, out_last, frame_err, in_ready);
        end
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_frame();
        max_run = 0;
        gen_frame(1);
        send_frame(16);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== (c == 2) || (c == 2 && out_index !== 5'd0)) begin
                n_errors++;
                $display("FAIL first_latency cycle %0d: got v=%b idx=%0d required v=%b idx=0", c + 1, out_valid, out_index, c == 2);
            end
        end
        drain();
        n_checks++;
        if (max_run != 32) begin
            n_errors++;
            $display("FAIL single_run: got %0d contiguous beats, required 32", max_run);
        end
    endtask

    task automatic test_back_to_back();
        max_run = 0;
        seen_nr = 0;
        for (int f = 0; f < 3; f++) begin
            gen_frame(0);
            send_frame(16);
        end
        drain();
        n_checks++;
        if (max_run != 96) begin
            n_errors++;
            $display("FAIL b2b_run: got %0d contiguous beats, required 96", max_run);
        end
        n_checks++;
        if (seen_nr == 0) begin
            n_errors++;
            $display("FAIL b2b_backpressure: got %0d not-ready cycles, required >0", seen_nr);
        end
    endtask

    task automatic test_random_ready();
        bit done = 0;
        gen_frame(0);
        send_frame(16);
        for (int t = 0; t < 1000 && !done; t++) begin
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            if (exp_q.size() == 0 && !out_valid) done = 1;
        end
        out_ready = 1'b1;
        n_checks++;
        if (!done) begin
            n_errors++;
            $display("FAIL rand_ready_drain: %0d beats pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_protocol_errors();
        err_count = 0;
        gen_frame(0);
        send_frame(7);
        gen_frame(0);
        send_frame(16);
        drain();
        n_checks++;
        if (err_count != 1) begin
            n_errors++;
            $display("FAIL abort_err_count: got %0d pulses, required 1", err_count);
        end
        err_count = 0;
        gen_frame(0);
        send_pair(1'b0, 3);
        repeat (6) @(negedge clk);
        n_checks++;
        if (err_count != 1 || out_valid !== 1'b0 || exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL idle_err: got pulses=%0d v=%b pending=%0d required 1/0/0", err_count, out_valid, exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_simultaneous();
        bit found = 0;
        gen_frame(0);
        send_frame(16);
        for (int t = 0; t < 100 && !found; t++) begin
            @(negedge clk);
            if (out_valid && out_index == 5'd15) found = 1;
        end
        n_checks++;
        if (!found) begin
            n_errors++;
            $display("FAIL simul_sync: bin 15 not seen, required within 100 cycles");
        end
        @(posedge clk);
        #1;
        gen_frame(0);
        send_frame(16);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (in_ready !== 1'b1 || out_valid !== (c == 2) || (c == 2 && out_index !== 5'd0)) begin
                n_errors++;
                $display("FAIL simul_edge cycle %0d: got rdy=%b v=%b idx=%0d required rdy=1 v=%b idx=0",
                         c + 1, in_ready, out_valid, out_index, c == 2);
            end
        end
        drain();
    endtask

    task automatic test_reset_mid_read();
        bit found = 0;
        gen_frame(0);
        send_frame(16);
        for (int t = 0; t < 100 && !found; t++) begin
            @(negedge clk);
            if (out_valid && out_index == 5'd12) found = 1;
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (!found || out_valid !== 1'b0 || out_re !== '0 || out_im !== '0 || out_index !== '0 ||
            out_last !== 1'b0 || in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_mid_read: got found=%b v=%b re=%h im=%h idx=%0d last=%b rdy=%b required 1/0/0/0/0/0/1",
                     found, out_valid, out_re, out_im, out_index, out_last, in_ready);
        end
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        gen_frame(0);
        send_frame(16);
        drain();
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_start = 1'b0;
        out_ready = 1'b1;
        in_re0 = '0;
        in_im0 = '0;
        in_re1 = '0;
        in_im1 = '0;
        err_count = 0;
        seen_nr = 0;
        max_run = 0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_random_ready();
        test_protocol_errors();
        test_simultaneous();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
